// File: rtl/byte_serial_tx.sv
// Parallel-to-serial word transmitter with a one-word holding buffer
// so consecutive words stream back to back without idle cycles.
module byte_serial_tx #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_valid_q;
  logic [CNT_W-1:0] word_count_q;

  logic at_last;
  logic load;

  assign at_last = (state_q == SHIFT) && (bit_cnt_q == LAST);
  assign load    = hold_valid_q && ((state_q == IDLE) || at_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      word_count_q <= '0;
    end else begin
      // accept needs an empty hold register, load needs a full one
      if (in_valid && !hold_valid_q) begin
        hold_q       <= in_data;
        hold_valid_q <= 1'b1;
      end
      if (at_last) begin
        word_count_q <= word_count_q + CNT_W'(1);
      end
      if (load) begin
        sr_q         <= hold_q;
        bit_cnt_q    <= '0;
        state_q      <= SHIFT;
        hold_valid_q <= 1'b0;
      end else if (at_last) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        bit_cnt_q <= bit_cnt_q + BW'(1);
        if (LSB_FIRST != 0) begin
          sr_q <= {1'b0, sr_q[WIDTH-1:1]};
        end else begin
          sr_q <= {sr_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  logic out_bit;

  assign out_bit    = (LSB_FIRST != 0) ? sr_q[0] : sr_q[WIDTH-1];
  assign ser_valid  = (state_q == SHIFT);
  assign ser_out    = ser_valid & out_bit;
  assign ser_first  = ser_valid & (bit_cnt_q == '0);
  assign ser_last   = at_last;
  assign in_ready   = !hold_valid_q;
  assign busy       = ser_valid | hold_valid_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_byte_serial_tx.sv
// Directed bench for byte_serial_tx: LSB-first, MSB-first and a
// narrow-counter instance share one clock and reset.
module tb_byte_serial_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic [7:0]  in_data_a = '0;
  logic        in_valid_a = 1'b0;
  logic        in_ready_a, ser_out_a, ser_valid_a;
  logic        ser_first_a, ser_last_a, busy_a;
  logic [15:0] wc_a;

  logic [7:0]  in_data_b = '0;
  logic        in_valid_b = 1'b0;
  logic        in_ready_b, ser_out_b, ser_valid_b;
  logic        ser_first_b, ser_last_b, busy_b;
  logic [15:0] wc_b;

  logic [7:0]  in_data_c = '0;
  logic        in_valid_c = 1'b0;
  logic        in_ready_c, ser_out_c, ser_valid_c;
  logic        ser_first_c, ser_last_c, busy_c;
  logic [1:0]  wc_c;

  byte_serial_tx #(.WIDTH(8), .LSB_FIRST(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .ser_out(ser_out_a), .ser_valid(ser_valid_a),
    .ser_first(ser_first_a), .ser_last(ser_last_a),
    .busy(busy_a), .word_count(wc_a)
  );

  byte_serial_tx #(.WIDTH(8), .LSB_FIRST(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .ser_out(ser_out_b), .ser_valid(ser_valid_b),
    .ser_first(ser_first_b), .ser_last(ser_last_b),
    .busy(busy_b), .word_count(wc_b)
  );

  byte_serial_tx #(.WIDTH(8), .LSB_FIRST(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst),
    .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .ser_out(ser_out_c), .ser_valid(ser_valid_c),
    .ser_first(ser_first_c), .ser_last(ser_last_c),
    .busy(busy_c), .word_count(wc_c)
  );

  int nchk = 0;
  int nfail = 0;

  int vcyc[$];
  bit vbit[$];
  bit vfirst[$];
  bit vlast[$];
  int n_acc;
  int ready_bad;

  // stream up to three words into dut_a and capture its serial output
  task automatic drive_a(input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input int n,
                         input int cycles);
    logic [7:0] ws[3];
    int idx;
    bit fire;
    ws = '{w0, w1, w2};
    idx = 0;
    fire = 1'b0;
    ready_bad = 0;
    vcyc.delete();
    vbit.delete();
    vfirst.delete();
    vlast.delete();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (fire) begin
        idx++;
        if (in_ready_a !== 1'b0) ready_bad++;
      end
      if (ser_valid_a === 1'b1) begin
        vcyc.push_back(c);
        vbit.push_back(ser_out_a);
        vfirst.push_back(ser_first_a);
        vlast.push_back(ser_last_a);
      end
      in_valid_a = (idx < n);
      in_data_a = (idx < n) ? ws[idx] : 8'h00;
      fire = in_valid_a && in_ready_a;
    end
    in_valid_a = 1'b0;
    n_acc = idx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    nchk++;
    if ({ser_valid_a, ser_out_a, ser_first_a, ser_last_a, busy_a,
         in_ready_a} !== 6'b000001) begin
      nfail++;
      $display("FAIL reset_a_flags got=%b want=000001",
        {ser_valid_a, ser_out_a, ser_first_a, ser_last_a, busy_a,
         in_ready_a});
    end
    nchk++;
    if ({wc_a, wc_b, wc_c} !== 34'd0) begin
      nfail++;
      $display("FAIL reset_counts got=%0d/%0d/%0d want=0", wc_a, wc_b, wc_c);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nchk++;
    if ({ser_valid_b, busy_b, in_ready_b, ser_valid_c, in_ready_c}
        !== 5'b00101) begin
      nfail++;
      $display("FAIL reset_bc_idle got=%b want=00101",
        {ser_valid_b, busy_b, in_ready_b, ser_valid_c, in_ready_c});
    end
  endtask

  task automatic test_lsb_single();
    logic [0:7] e;
    int err;
    e = 8'b0100_1011;
    drive_a(8'hD2, 8'h00, 8'h00, 1, 12);
    nchk++;
    if (vbit.size() != 8) begin
      nfail++;
      $display("FAIL lsb_count got=%0d want=8", vbit.size());
    end else begin
      err = 0;
      for (int i = 0; i < 8; i++) begin
        if (vbit[i] != e[i]) err++;
        if (vfirst[i] != (i == 0)) err++;
        if (vlast[i] != (i == 7)) err++;
      end
      nchk++;
      if (err != 0) begin
        nfail++;
        $display("FAIL lsb_bits errors=%0d want=0", err);
      end
      nchk++;
      if (vcyc[0] != 2 || vcyc[7] != 9) begin
        nfail++;
        $display("FAIL lsb_latency got=%0d..%0d want=2..9", vcyc[0], vcyc[7]);
      end
    end
    nchk++;
    if (wc_a !== 16'd1 || ser_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      nfail++;
      $display("FAIL lsb_after wc=%0d v=%b busy=%b want wc=1 v=0 busy=0",
        wc_a, ser_valid_a, busy_a);
    end
  endtask

  task automatic test_msb_single();
    logic [0:7] e;
    e = 8'b1010_0101;
    @(negedge clk);
    in_data_b = 8'hA5;
    in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0;
    nchk++;
    if (in_ready_b !== 1'b0 || busy_b !== 1'b1) begin
      nfail++;
      $display("FAIL msb_held rdy=%b busy=%b want rdy=0 busy=1",
        in_ready_b, busy_b);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nchk++;
      if ({ser_valid_b, ser_out_b} !== {1'b1, e[i]}) begin
        nfail++;
        $display("FAIL msb_bit%0d got=%b want=1%b", i,
          {ser_valid_b, ser_out_b}, e[i]);
      end
    end
    @(negedge clk);
    nchk++;
    if (wc_b !== 16'd1 || ser_valid_b !== 1'b0) begin
      nfail++;
      $display("FAIL msb_after wc=%0d v=%b want wc=1 v=0", wc_b, ser_valid_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:15] e;
    int err;
    e = 16'b1000_0000_0000_0001;
    drive_a(8'h01, 8'h80, 8'h00, 2, 20);
    nchk++;
    if (vbit.size() != 16 || vcyc[15] - vcyc[0] != 15) begin
      nfail++;
      $display("FAIL b2b_contig got=%0d bits want=16 contiguous", vbit.size());
    end else begin
      err = 0;
      for (int i = 0; i < 16; i++) begin
        if (vbit[i] != e[i]) err++;
        if (vfirst[i] != (i % 8 == 0)) err++;
        if (vlast[i] != (i % 8 == 7)) err++;
      end
      nchk++;
      if (err != 0) begin
        nfail++;
        $display("FAIL b2b_bits errors=%0d want=0", err);
      end
    end
    nchk++;
    if (wc_a !== 16'd3 || ser_valid_a !== 1'b0) begin
      nfail++;
      $display("FAIL b2b_after wc=%0d v=%b want wc=3 v=0", wc_a, ser_valid_a);
    end
  endtask

  task automatic test_backpressure();
    logic [0:23] e;
    int err;
    e = 24'b0100_1000_1101_0110_0000_0111;
    drive_a(8'h12, 8'h6B, 8'hE0, 3, 32);
    nchk++;
    if (n_acc != 3 || ready_bad != 0) begin
      nfail++;
      $display("FAIL bp_accept got=%0d accepts %0d ready-high want=3/0",
        n_acc, ready_bad);
    end
    nchk++;
    if (vbit.size() != 24 || vcyc[23] - vcyc[0] != 23) begin
      nfail++;
      $display("FAIL bp_contig got=%0d bits want=24 contiguous", vbit.size());
    end else begin
      err = 0;
      for (int i = 0; i < 24; i++) if (vbit[i] != e[i]) err++;
      nchk++;
      if (err != 0) begin
        nfail++;
        $display("FAIL bp_bits errors=%0d want=0", err);
      end
    end
    nchk++;
    if (wc_a !== 16'd6) begin
      nfail++;
      $display("FAIL bp_count got=%0d want=6", wc_a);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [0:7] e;
    int err;
    e = 8'b1111_0000;
    @(negedge clk);
    in_data_a = 8'hFF;
    in_valid_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    @(negedge clk);
    nchk++;
    if ({ser_valid_a, ser_out_a, in_ready_a} !== 3'b110) begin
      nfail++;
      $display("FAIL mid_pre got=%b want=110",
        {ser_valid_a, ser_out_a, in_ready_a});
    end
    #2;
    rst = 1'b1;
    #1;
    nchk++;
    if ({ser_valid_a, ser_out_a, in_ready_a, busy_a} !== 4'b0010 ||
        wc_a !== 16'd0) begin
      nfail++;
      $display("FAIL mid_reset got=%b wc=%0d want=0010 wc=0",
        {ser_valid_a, ser_out_a, in_ready_a, busy_a}, wc_a);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_a(8'h0F, 8'h00, 8'h00, 1, 12);
    err = (vbit.size() == 8) ? 0 : 1;
    for (int i = 0; i < vbit.size() && i < 8; i++) if (vbit[i] != e[i]) err++;
    nchk++;
    if (err != 0 || wc_a !== 16'd1) begin
      nfail++;
      $display("FAIL mid_resend errors=%0d wc=%0d want=0 wc=1", err, wc_a);
    end
  endtask

  task automatic test_count_wrap();
    logic [1:0] ex[5];
    int acc, k;
    bit fire, prev_last;
    ex = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    acc = 0;
    k = 0;
    fire = 1'b0;
    prev_last = 1'b0;
    for (int c = 0; c < 80 && k < 5; c++) begin
      @(negedge clk);
      if (fire) acc++;
      if (prev_last) begin
        nchk++;
        if (wc_c !== ex[k]) begin
          nfail++;
          $display("FAIL wrap_word%0d got=%0d want=%0d", k, wc_c, ex[k]);
        end
        k++;
      end
      prev_last = ser_last_c;
      in_valid_c = (acc < 5);
      in_data_c = 8'(8'h30 + acc);
      fire = in_valid_c && in_ready_c;
    end
    in_valid_c = 1'b0;
    nchk++;
    if (k != 5) begin
      nfail++;
      $display("FAIL wrap_timeout got=%0d words want=5", k);
    end
  endtask

  initial begin
    test_reset();
    test_lsb_single();
    test_msb_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
      nchk, nfail);
    $finish;
  end

endmodule
